conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_window_gen_if.sv | 26 ++
 rtl/line_buffer.sv | 23 ++
 rtl/conv_window_gen.sv | 102 ++++++++++
 tb/tb_conv_window_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared sizing for the convolution datapath (window generator and conv_block).
// Pure constants and helpers; no logic, no latency.
package conv_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int IMAGE_SIZE  = 16;
  localparam int KERNEL_SIZE = 3;
  localparam int ADDR_SIZE   = 4;
  localparam int MAX_ADDRESS = IMAGE_SIZE - 1;
  localparam int WIN_TAPS    = KERNEL_SIZE * KERNEL_SIZE;

  typedef logic [DATA_WIDTH-1:0] pix_t;

  // Valid (unpadded) windows produced per frame.
  function automatic int windows_per_frame(input int img, input int k);
    return (img - k + 1) * (img - k + 1);
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream in, 3x3 window out; master is the pixel source, slave the window generator.
// Valid-only flow: the stream has no ready, so the source never stalls.
interface conv_window_gen_if #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  pix_valid;
  logic                  clr;
  logic [DATA_WIDTH-1:0] ImgP1, ImgP2, ImgP3;
  logic [DATA_WIDTH-1:0] ImgP4, ImgP5, ImgP6;
  logic [DATA_WIDTH-1:0] ImgP7, ImgP8, ImgP9;
  logic                  win_valid;
  logic                  win_last;

  modport master (
    output pix_in, pix_valid, clr,
    input  ImgP1, ImgP2, ImgP3, ImgP4, ImgP5, ImgP6, ImgP7, ImgP8, ImgP9,
    input  win_valid, win_last
  );

  modport slave (
    input  pix_in, pix_valid, clr,
    output ImgP1, ImgP2, ImgP3, ImgP4, ImgP5, ImgP6, ImgP7, ImgP8, ImgP9,
    output win_valid, win_last
  );
endinterface

// File: rtl/line_buffer.sv
// One image row of storage: combinational read, write on clk, so a same-address
// access returns the old word (read-before-write). Not reset; maps to RAM/SRL.
module line_buffer #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int ADDR_SIZE  = conv_pkg::ADDR_SIZE,
  parameter int DEPTH      = conv_pkg::IMAGE_SIZE
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_SIZE-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Builds 3x3 windows from a raster pixel stream; window appears 1 cycle after its
// bottom-right pixel. No backpressure: every pix_valid cycle is consumed (clr drops it).
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMAGE_SIZE  = conv_pkg::IMAGE_SIZE,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
  parameter int ADDR_SIZE   = conv_pkg::ADDR_SIZE,
  parameter int MAX_ADDRESS = conv_pkg::MAX_ADDRESS
) (
  input  logic             clk,
  input  logic             rst,
  conv_window_gen_if.slave bus
);

  localparam logic [ADDR_SIZE-1:0] LAST_COL   = ADDR_SIZE'(MAX_ADDRESS);
  localparam logic [ADDR_SIZE-1:0] LAST_ROW   = ADDR_SIZE'(IMAGE_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] FIRST_FULL = ADDR_SIZE'(KERNEL_SIZE - 1);

  logic [ADDR_SIZE-1:0]  col_cnt, row_cnt;
  logic [DATA_WIDTH-1:0] lb0_q, lb1_q;
  logic [DATA_WIDTH-1:0] win [9];
  logic                  win_valid_q, win_last_q;
  logic                  accept;

  // clr has priority: a pixel arriving with clr is dropped.
  assign accept = bus.pix_valid & ~bus.clr;

  // lb0 holds the previous row, lb1 the one before; lb1 is refilled from lb0's old word.
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_SIZE(ADDR_SIZE), .DEPTH(IMAGE_SIZE)) u_lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (col_cnt),
    .din  (bus.pix_in),
    .dout (lb0_q)
  );

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_SIZE(ADDR_SIZE), .DEPTH(IMAGE_SIZE)) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (col_cnt),
    .din  (lb0_q),
    .dout (lb1_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (bus.clr) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_cnt == LAST_COL) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + ADDR_SIZE'(1);
      end else begin
        col_cnt <= col_cnt + ADDR_SIZE'(1);
      end
    end
  end

  // Window rows shift left; right column is {row r-2, row r-1, row r} at this column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r*3]   <= win[r*3+1];
        win[r*3+1] <= win[r*3+2];
      end
      win[2] <= lb1_q;
      win[5] <= lb0_q;
      win[8] <= bus.pix_in;
    end
  end

  // Gating on row/col >= 2 keeps stale buffer data and row/frame wraps out of valid windows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      win_valid_q <= accept && (row_cnt >= FIRST_FULL) && (col_cnt >= FIRST_FULL);
      win_last_q  <= accept && (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
    end
  end

  assign bus.ImgP1     = win[0];
  assign bus.ImgP2     = win[1];
  assign bus.ImgP3     = win[2];
  assign bus.ImgP4     = win[3];
  assign bus.ImgP5     = win[4];
  assign bus.ImgP6     = win[5];
  assign bus.ImgP7     = win[6];
  assign bus.ImgP8     = win[7];
  assign bus.ImgP9     = win[8];
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: directed frames plus random data/gaps, checked against
// a frame-array model that derives each window from pixel coordinates.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int N = IMAGE_SIZE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_gen_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  conv_window_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: pixels of the current frame by coordinate, index of next pixel.
  pix_t frame [N][N];
  int   k;
  pix_t exp_win [9];
  bit   exp_known;
  int   nwin;
  int   nlast;

  function automatic pix_t obs(input int i);
    case (i)
      0: return bus.ImgP1;
      1: return bus.ImgP2;
      2: return bus.ImgP3;
      3: return bus.ImgP4;
      4: return bus.ImgP5;
      5: return bus.ImgP6;
      6: return bus.ImgP7;
      7: return bus.ImgP8;
      default: return bus.ImgP9;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_restart();
    k         = 0;
    exp_known = 0;
  endtask

  // Apply one cycle of inputs, advance the model, then check outputs 1ns after the edge.
  task automatic cyc(input bit v, input pix_t p, input bit c);
    int  r, cc;
    bit  ev, el;
    bus.pix_valid = v;
    bus.pix_in    = p;
    bus.clr       = c;
    ev = 0;
    el = 0;
    if (c) begin
      model_restart();
    end else if (v) begin
      r  = k / N;
      cc = k % N;
      frame[r][cc] = p;
      if (r >= 2 && cc >= 2) begin
        ev = 1;
        el = (r == N - 1) && (cc == N - 1);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[i*3+j] = frame[r-2+i][cc-2+j];
        exp_known = 1;
      end else begin
        exp_known = 0;
      end
      k = (k + 1) % (N * N);
    end
    @(posedge clk);
    #1;
    check("win_valid", bus.win_valid, ev);
    check("win_last", bus.win_last, el);
    if (bus.win_valid === 1'b1) nwin++;
    if (bus.win_last === 1'b1) nlast++;
    if (exp_known)
      for (int i = 0; i < 9; i++) check($sformatf("ImgP%0d", i + 1), obs(i), exp_win[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.win_valid, 0);
    check({tag, "_last"}, bus.win_last, 0);
    for (int i = 0; i < 9; i++) check($sformatf("%s_ImgP%0d", tag, i + 1), obs(i), 0);
  endtask

  task automatic start_count();
    nwin  = 0;
    nlast = 0;
  endtask

  task automatic end_count(input string tag);
    check({tag, "_windows"}, nwin, windows_per_frame(N, KERNEL_SIZE));
    check({tag, "_lasts"}, nlast, 1);
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.clr       = 1'b0;
    rst           = 1'b0;
    model_restart();

    // Reset state
    #12;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame, continuous valid; explicit first/last window values
    start_count();
    for (int i = 0; i < N * N; i++) begin
      cyc(1'b1, pix_t'((i / N) * 16 + (i % N)), 1'b0);
      if (i == 34) begin
        check("first_P1", bus.ImgP1, 16'h0000);
        check("first_P5", bus.ImgP5, 16'h0011);
        check("first_P9", bus.ImgP9, 16'h0022);
      end
      if (i == N * N - 1) begin
        check("final_P1", bus.ImgP1, 16'h00DD);
        check("final_P9", bus.ImgP9, 16'h00FF);
        check("final_last", bus.win_last, 1);
      end
    end
    end_count("ramp");

    // Same frame with valid toggling every cycle
    start_count();
    for (int i = 0; i < N * N; i++) begin
      cyc(1'b1, pix_t'((i / N) * 16 + (i % N)), 1'b0);
      cyc(1'b0, pix_t'($urandom), 1'b0);
    end
    end_count("toggle");

    // Back-to-back frame with +0x100 values
    start_count();
    for (int i = 0; i < N * N; i++) begin
      cyc(1'b1, pix_t'(16'h100 + (i / N) * 16 + (i % N)), 1'b0);
      if (i == 34) begin
        check("f2_first_P1", bus.ImgP1, 16'h0100);
        check("f2_first_P9", bus.ImgP9, 16'h0122);
      end
    end
    end_count("frame2");

    // Random data with random gaps
    start_count();
    for (int i = 0; i < N * N; ) begin
      if ($urandom_range(9) < 7) begin
        cyc(1'b1, pix_t'($urandom), 1'b0);
        i++;
      end else begin
        cyc(1'b0, pix_t'($urandom), 1'b0);
      end
    end
    end_count("random");

    // Reset mid-frame after 40 pixels
    for (int i = 0; i < 40; i++) cyc(1'b1, pix_t'($urandom), 1'b0);
    bus.pix_valid = 1'b0;
    rst = 1'b0;
    #2;
    check_all_zero("midrst");
    model_restart();
    @(negedge clk);
    check_all_zero("midrst_hold");
    rst = 1'b1;
    start_count();
    for (int i = 0; i < N * N; i++) begin
      cyc(1'b1, pix_t'(16'h200 + (i / N) * 16 + (i % N)), 1'b0);
      if (i == 34) check("rst_first_P1", bus.ImgP1, 16'h0200);
    end
    end_count("after_rst");

    // clr with a valid pixel at index 20: pixel dropped, next pixel is (0,0)
    for (int i = 0; i < 20; i++) cyc(1'b1, pix_t'($urandom), 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b1);
    start_count();
    for (int i = 0; i < N * N; i++) begin
      if ($urandom_range(3) == 0) cyc(1'b0, pix_t'($urandom), 1'b0);
      cyc(1'b1, pix_t'(16'h300 + (i / N) * 16 + (i % N)), 1'b0);
      if (i == 34) check("clr_first_P1", bus.ImgP1, 16'h0300);
    end
    end_count("after_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
